// File: rtl/checker_pkg.sv
// Shared types and default sizing for the response checker and its compare stage.
package checker_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_N_VECTORS = 65536;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/response_checker_if.sv
// Vector handshake between the stimulus source and the checker: a/b stimulus, y response.
interface response_checker_if #(
    parameter int WIDTH = 16
);
    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;

    modport master (
        output vec_valid, a, b, y,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, a, b, y,
        output vec_ready
    );
endinterface

// File: rtl/response_compare.sv
// Compare stage: captures an accepted vector and flags y != a & b one cycle later.
module response_compare
    import checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_accept,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH:0]   i_index,
    output logic             o_valid,
    output logic             o_mismatch,
    output logic [WIDTH:0]   o_index,
    output logic [WIDTH-1:0] o_expected,
    output logic [WIDTH-1:0] o_actual
);

    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH:0]   r_index;
    logic [WIDTH-1:0] w_expected;

    // NOTE: non-blocking assignments in clocked blocks keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_accept;
        end
    end

    // NOTE: data registers carry no reset; r_valid alone qualifies them, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (i_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_y     <= i_y;
            r_index <= i_index;
        end
    end

    assign w_expected = r_a & r_b;

    assign o_valid    = r_valid;
    assign o_mismatch = (r_y != w_expected);
    assign o_index    = r_index;
    assign o_expected = w_expected;
    assign o_actual   = r_y;

endmodule

// File: rtl/response_checker.sv
// Run controller: accepts N_VECTORS vectors, counts mismatches and records the first failure.
module response_checker
    import checker_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int N_VECTORS = DEFAULT_N_VECTORS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    response_checker_if.slave vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [WIDTH:0]    count,
    output logic [WIDTH:0]    errors,
    output logic [WIDTH:0]    fail_index,
    output logic [WIDTH-1:0]  fail_expected,
    output logic [WIDTH-1:0]  fail_actual
);

    localparam logic [WIDTH:0] LP_LAST    = (WIDTH + 1)'(N_VECTORS);
    localparam logic [WIDTH:0] LP_ERR_MAX = '1;

    state_t           r_state;
    logic             r_vec_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [WIDTH:0]   r_count;
    logic [WIDTH:0]   r_errors;
    logic [WIDTH:0]   r_fail_index;
    logic [WIDTH-1:0] r_fail_expected;
    logic [WIDTH-1:0] r_fail_actual;

    logic             w_accept;
    logic [WIDTH:0]   w_count_inc;
    logic             w_cmp_valid;
    logic             w_cmp_mismatch;
    logic [WIDTH:0]   w_cmp_index;
    logic [WIDTH-1:0] w_cmp_expected;
    logic [WIDTH-1:0] w_cmp_actual;
    logic             w_err_hit;
    logic [WIDTH:0]   w_errors_next;

    assign w_accept    = vec.vec_valid & r_vec_ready;
    assign w_count_inc = r_count + 1'b1;
    assign w_err_hit   = w_cmp_valid & w_cmp_mismatch;

    response_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .clk        (clk),
        .reset      (reset),
        .i_accept   (w_accept),
        .i_a        (vec.a),
        .i_b        (vec.b),
        .i_y        (vec.y),
        .i_index    (r_count),
        .o_valid    (w_cmp_valid),
        .o_mismatch (w_cmp_mismatch),
        .o_index    (w_cmp_index),
        .o_expected (w_cmp_expected),
        .o_actual   (w_cmp_actual)
    );

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_errors_next = r_errors;
        if (w_err_hit && (r_errors != LP_ERR_MAX)) begin
            w_errors_next = r_errors + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_vec_ready     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_count         <= '0;
            r_errors        <= '0;
            r_fail_index    <= '0;
            r_fail_expected <= '0;
            r_fail_actual   <= '0;
        end else begin
            // A compare only completes in RUN or DRAIN, so it never collides with the clear on start.
            if (w_err_hit) begin
                r_errors <= w_errors_next;
                if (r_errors == '0) begin
                    r_fail_index    <= w_cmp_index;
                    r_fail_expected <= w_cmp_expected;
                    r_fail_actual   <= w_cmp_actual;
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state         <= RUN;
                        r_vec_ready     <= 1'b1;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                        r_count         <= '0;
                        r_errors        <= '0;
                        r_fail_index    <= '0;
                        r_fail_expected <= '0;
                        r_fail_actual   <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_count <= w_count_inc;
                        if (w_count_inc == LP_LAST) begin
                            r_state     <= DRAIN;
                            r_vec_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_errors_next == '0);
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign vec.vec_ready  = r_vec_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign count          = r_count;
    assign errors         = r_errors;
    assign fail_index     = r_fail_index;
    assign fail_expected  = r_fail_expected;
    assign fail_actual    = r_fail_actual;

endmodule

// File: tb/tb_response_checker.sv
// Scoreboard bench: each run pushes its expected summary, a monitor checks it when done rises.
module tb_response_checker;
    import checker_pkg::*;

    localparam int W = 16;
    localparam int N = 4800;

    typedef struct {
        int count;
        int errors;
        int fidx;
        int fexp;
        int fact;
        int pass;
        int busy_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, pass;
    logic [W:0]   count, errors, fail_index;
    logic [W-1:0] fail_expected, fail_actual;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    response_checker_if #(.WIDTH(W)) vif();

    response_checker #(
        .WIDTH     (W),
        .N_VECTORS (N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .vec           (vif),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .count         (count),
        .errors        (errors),
        .fail_index    (fail_index),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] vec_a(input int pat, input int i);
        logic [W-1:0] iv;
        iv = W'(i);
        return (pat == 0) ? iv : ((iv * 16'd37) ^ 16'hC3A5);
    endfunction

    function automatic logic [W-1:0] vec_b(input int pat, input int i);
        logic [W-1:0] iv;
        iv = W'(i);
        return (pat == 0) ? ~iv : ({iv[7:0], iv[15:8]} ^ 16'h0FF0);
    endfunction

    function automatic logic [W-1:0] vec_y(input int pat, input int i, input int f0, input int f1);
        logic [W-1:0] y;
        y = vec_a(pat, i) & vec_b(pat, i);
        if (i == f0) y = y ^ 16'h0001;
        if (i == f1) y = y ^ 16'h8000;
        return y;
    endfunction

    // Starts a run and drives vectors; abort_at >= 0 stops early and queues no expectation.
    task automatic run_vectors(input int pat, input int f0, input int f1, input bit tog,
                               input int mid_start, input int abort_at, input exp_t e);
        int i;
        int cyc;
        bit v;
        i = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        if (abort_at < 0) sb.push_back(e);
        while (i < N && i != abort_at && cyc < 4 * N + 20) begin
            @(negedge clk);
            cyc++;
            start = (i == mid_start);
            if (cyc == 1) begin
                check("run_start_busy", 32'(busy), 1);
                check("run_start_ready", 32'(vif.vec_ready), 1);
                check("run_start_count", 32'(count), 0);
                check("run_start_errors", 32'(errors), 0);
                check("run_start_fail_index", 32'(fail_index), 0);
                check("run_start_done", 32'(done), 0);
            end
            v = tog ? (cyc % 2 == 0) : 1'b1;
            vif.vec_valid = v;
            vif.a = vec_a(pat, i);
            vif.b = vec_b(pat, i);
            vif.y = vec_y(pat, i, f0, f1);
            if (v && vif.vec_ready) i++;
        end
        @(negedge clk);
        vif.vec_valid = 1'b0;
        start = 1'b0;
        if (abort_at < 0) begin
            check("drive_complete", i, N);
            for (int k = 0; k < 8 && !done; k++) @(negedge clk);
            check("done_seen", 32'(done), 1);
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        int busy_cnt;
        bit done_q;
        bit busy_q;
        exp_t e;
        busy_cnt = 0;
        done_q = 1'b0;
        busy_q = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !busy_q) busy_cnt = 0;
            if (busy) busy_cnt++;
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_count", 32'(count), e.count);
                    check("sb_errors", 32'(errors), e.errors);
                    check("sb_fail_index", 32'(fail_index), e.fidx);
                    check("sb_fail_expected", 32'(fail_expected), e.fexp);
                    check("sb_fail_actual", 32'(fail_actual), e.fact);
                    check("sb_pass", 32'(pass), e.pass);
                    check("sb_busy_cycles", busy_cnt, e.busy_cycles);
                    check("sb_ready_low", 32'(vif.vec_ready), 0);
                end
            end
            done_q = done;
            busy_q = busy;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        exp_t dummy;
        dummy = '{0, 0, 0, 0, 0, 0, 0};
        vif.vec_valid = 1'b0;
        vif.a = '0;
        vif.b = '0;
        vif.y = '0;

        // Reset state, then idle until start.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_ready", 32'(vif.vec_ready), 0);
        check("rst_count", 32'(count), 0);
        check("rst_errors", 32'(errors), 0);
        check("rst_fail_index", 32'(fail_index), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_ready", 32'(vif.vec_ready), 0);

        // Clean run, a=i b=~i y=0.
        run_vectors(0, -1, -1, 1'b0, -1, -1, '{N, 0, 0, 0, 0, 1, N + 1});
        // Single fault at 0x1234: expected 0x0000, actual 0x0001.
        run_vectors(0, 'h1234, -1, 1'b0, -1, -1, '{N, 1, 'h1234, 'h0000, 'h0001, 0, N + 1});
        // Faults at 5 and 9: first capture stays at 5 (a&b = 0xC31C & 0x0AF0 = 0x0210).
        run_vectors(1, 5, 9, 1'b0, -1, -1, '{N, 2, 5, 'h0210, 'h0211, 0, N + 1});
        // Restart from DONE clears errors at once; valid toggles 0/1.
        run_vectors(1, -1, -1, 1'b1, -1, -1, '{N, 0, 0, 0, 0, 1, 2 * N + 1});
        // start pulsed mid-run must be ignored.
        run_vectors(0, -1, -1, 1'b0, 2000, -1, '{N, 0, 0, 0, 0, 1, N + 1});

        // Stall after 100 accepts, then reset mid-run.
        run_vectors(0, -1, -1, 1'b0, -1, 100, dummy);
        repeat (5) @(negedge clk);
        check("stall_count", 32'(count), 100);
        check("stall_errors", 32'(errors), 0);
        check("stall_busy", 32'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(vif.vec_ready), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_done", 32'(done), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_idle", 32'(busy), 0);
        run_vectors(1, -1, -1, 1'b0, -1, -1, '{N, 0, 0, 0, 0, 1, N + 1});

        // start and reset together in DONE: reset wins, stays IDLE.
        @(negedge clk);
        start = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        check("startrst_busy", 32'(busy), 0);
        check("startrst_done", 32'(done), 0);
        check("startrst_ready", 32'(vif.vec_ready), 0);
        repeat (3) @(negedge clk);
        check("startrst_idle", 32'(busy), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
